// File: rtl/ib_lut_mem_pkg.sv
// Shared types and helpers for the ping-pong IB LUT store.
package ib_lut_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_e;

    // Word counter must hold the full-set count, not just the last index.
    function automatic int unsigned cnt_width(input int unsigned bank_num,
                                              input int unsigned page_num);
        return $clog2(bank_num * page_num + 1);
    endfunction

endpackage

// File: rtl/ib_lut_mem_pingpong_if.sv
// LUT load stream: valid/ready word transfer into the shadow set.
interface ib_lut_mem_pingpong_if #(
    parameter int unsigned QUAN_SIZE = 3
);
    logic [QUAN_SIZE-1:0] load_data;
    logic                 load_valid;
    logic                 load_ready;

    modport master (output load_data, output load_valid, input load_ready);
    modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/ib_lut_mem_pingpong_bank.sv
// One LUT bank: synchronous write, combinational read, distributed RAM.
module lut_mem_bank_sdp_1clk #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              sys_clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    (* ram_style = "distributed" *) logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ib_lut_mem_pingpong.sv
// Double-buffered multi-bank IB LUT: lanes read the active set while the
// load FSM fills the shadow set; an explicit swap flips the sets.
module ib_lut_mem_pingpong
    import ib_lut_mem_pkg::*;
#(
    parameter int unsigned QUAN_SIZE     = 3,
    parameter int unsigned PAGE_NUM      = 16,
    parameter int unsigned ADDR_BITWIDTH = 4,
    parameter int unsigned BANK_NUM      = 4,
    parameter int unsigned READ_LATENCY  = 0
) (
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic [BANK_NUM*ADDR_BITWIDTH-1:0] read_addr_i,
    output logic [BANK_NUM*QUAN_SIZE-1:0]     read_page_o,
    input  logic                              load_start_i,
    ib_lut_mem_pingpong_if.slave              load_if,
    input  logic                              swap_en_i,
    output logic                              load_busy_o,
    output logic                              swap_pending_o,
    output logic                              swap_done_o,
    output logic                              active_sel_o
);
    localparam int unsigned CNT_W = cnt_width(BANK_NUM, PAGE_NUM);
    localparam int unsigned WORDS = BANK_NUM * PAGE_NUM;

    lut_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               pend_q, pend_d;
    logic               done_q, done_d;
    logic               accept_c;
    logic [CNT_W-1:0]   wbank_c;
    logic [ADDR_BITWIDTH-1:0] waddr_c;
    logic [1:0][BANK_NUM-1:0][QUAN_SIZE-1:0] rdata_c;
    logic [BANK_NUM*QUAN_SIZE-1:0]           page_c;

    assign accept_c = load_if.load_valid & ready_q;
    assign wbank_c  = cnt_q / CNT_W'(PAGE_NUM);
    assign waddr_c  = ADDR_BITWIDTH'(cnt_q % CNT_W'(PAGE_NUM));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORDS - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (swap_en_i) begin
                    sel_d   = ~sel_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
        pend_d  = (state_d == COMMIT);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // Writes only ever target the shadow set, so no read/write collision exists.
    for (genvar s = 0; s < 2; s++) begin : g_set
        for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
            logic we_c;
            assign we_c = accept_c && (wbank_c == CNT_W'(b)) && (sel_q != 1'(s));
            lut_mem_bank_sdp_1clk #(
                .DATA_W (QUAN_SIZE),
                .DEPTH  (PAGE_NUM),
                .ADDR_W (ADDR_BITWIDTH)
            ) u_bank (
                .sys_clk (sys_clk),
                .we_i    (we_c),
                .waddr_i (waddr_c),
                .wdata_i (load_if.load_data),
                .raddr_i (read_addr_i[b*ADDR_BITWIDTH +: ADDR_BITWIDTH]),
                .rdata_o (rdata_c[s][b])
            );
        end
    end

    always_comb begin
        page_c = '0;
        for (int b = 0; b < int'(BANK_NUM); b++) begin
            page_c[b*QUAN_SIZE +: QUAN_SIZE] = rdata_c[sel_q][b];
        end
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
        assign read_page_o = page_c;
    end else begin : g_rd_reg
        // Uses pre-edge sel_q, so a read on the swap edge returns old-set data.
        logic [BANK_NUM*QUAN_SIZE-1:0] page_q;
        always_ff @(posedge sys_clk) begin
            if (rst) page_q <= '0;
            else     page_q <= page_c;
        end
        assign read_page_o = page_q;
    end

    assign load_if.load_ready = ready_q;
    assign load_busy_o        = busy_q;
    assign swap_pending_o     = pend_q;
    assign swap_done_o        = done_q;
    assign active_sel_o       = sel_q;
endmodule
